// File: rtl/mem_req_bridge_pkg.sv
// Shared definitions for the CPU-to-memory request bridge.
//   - Default bus widths (64-word memory, 32-bit data).
//   - FSM state encoding shared with the CPU and memory-side bus logic.
package mem_req_bridge_pkg;

  localparam int unsigned DefaultAddrWidth = 6;
  localparam int unsigned DefaultDataWidth = 32;
  localparam int unsigned DefaultDepth     = 4;
  localparam int unsigned DefaultTimeout   = 16;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StResp = 2'd2
  } state_e;

endpackage

// File: rtl/mem_req_bridge_req_fifo.sv
// Synchronous request FIFO for the bridge.
// Ports:
//   clk, reset      - rising-edge clock, async active-high reset
//   push, wr_data   - write entry at tail (ignored when full)
//   pop, rd_data    - head entry is visible on rd_data; pop advances it (ignored when empty)
//   full, empty     - status decoded from registered count
//   count           - occupancy, 0..DEPTH
module mem_req_bridge_req_fifo #(
  parameter int unsigned WIDTH = 39,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             push_en, pop_en;

  assign full    = (count_q == CntW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];

  // Push depends only on the registered full flag, so a full FIFO refuses
  // a push even in a cycle where it is also being popped.
  assign push_en = push && !full;
  assign pop_en  = pop && !empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_en) begin
        mem_q[wr_ptr_q] <= wr_data;
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (pop_en) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      case ({push_en, pop_en})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/mem_req_bridge.sv
// Request-buffering bridge between the CPU and memory. Queues CPU requests,
// issues one at a time to memory, returns a one-cycle response, and converts
// a missing memory acknowledge into an error response after TIMEOUT cycles.
// Ports:
//   clk, reset                         - clock, async active-high reset
//   cpu_req_valid/ready, cpu_we,
//   cpu_addr, cpu_wdata                - CPU request channel
//   cpu_rsp_valid, cpu_rdata,
//   cpu_rsp_err                        - CPU response (one-cycle pulse)
//   mem_req_valid, mem_we, mem_addr,
//   mem_wdata                          - memory request, held until ack
//   mem_data_valid, mem_rdata          - memory ack / read data
//   busy                               - work in flight or queued
module mem_req_bridge
  import mem_req_bridge_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DefaultAddrWidth,
  parameter int unsigned DATA_WIDTH = DefaultDataWidth,
  parameter int unsigned DEPTH      = DefaultDepth,
  parameter int unsigned TIMEOUT    = DefaultTimeout
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_req_valid,
  output logic                  cpu_req_ready,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_rsp_valid,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_rsp_err,
  output logic                  mem_req_valid,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_data_valid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy
);

  localparam int unsigned Width = 1 + ADDR_WIDTH + DATA_WIDTH;
  localparam int unsigned TCntW = $clog2(TIMEOUT);

  state_e                state_q, state_d;
  logic [TCntW-1:0]      cnt_q, cnt_d;
  logic                  hold_we_q, hold_we_d;
  logic [ADDR_WIDTH-1:0] hold_addr_q, hold_addr_d;
  logic [DATA_WIDTH-1:0] hold_wdata_q, hold_wdata_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;

  logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [Width-1:0]      fifo_wr_data, fifo_rd_data;
  logic [$clog2(DEPTH):0] fifo_count;

  assign cpu_req_ready = !fifo_full;
  assign fifo_push     = cpu_req_valid && !fifo_full;
  assign fifo_wr_data  = {cpu_we, cpu_addr, cpu_wdata};

  mem_req_bridge_req_fifo #(
    .WIDTH (Width),
    .DEPTH (DEPTH)
  ) u_req_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (fifo_push),
    .wr_data (fifo_wr_data),
    .pop     (fifo_pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    hold_we_d    = hold_we_q;
    hold_addr_d  = hold_addr_q;
    hold_wdata_d = hold_wdata_q;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_err_d    = rsp_err_q;
    fifo_pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          fifo_pop                                = 1'b1;
          {hold_we_d, hold_addr_d, hold_wdata_d}  = fifo_rd_data;
          cnt_d                                   = '0;
          state_d                                 = StBusy;
        end
      end
      StBusy: begin
        // An ack in the final timeout cycle still wins over the error.
        if (mem_data_valid) begin
          rsp_rdata_d = hold_we_q ? '0 : mem_rdata;
          rsp_err_d   = 1'b0;
          state_d     = StResp;
        end else if (cnt_q == TCntW'(TIMEOUT - 1)) begin
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          state_d     = StResp;
        end else begin
          cnt_d = cnt_q + TCntW'(1);
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      hold_we_q    <= 1'b0;
      hold_addr_q  <= '0;
      hold_wdata_q <= '0;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      hold_we_q    <= hold_we_d;
      hold_addr_q  <= hold_addr_d;
      hold_wdata_q <= hold_wdata_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign mem_req_valid = (state_q == StBusy);
  assign mem_we        = hold_we_q;
  assign mem_addr      = hold_addr_q;
  assign mem_wdata     = hold_wdata_q;
  assign cpu_rsp_valid = (state_q == StResp);
  assign cpu_rdata     = rsp_rdata_q;
  assign cpu_rsp_err   = rsp_err_q;
  assign busy          = (state_q != StIdle) || (fifo_count != '0);

endmodule

// File: tb/tb_mem_req_bridge.sv
module tb_mem_req_bridge;

  localparam int unsigned AW = 6;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_req_valid, cpu_req_ready, cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_rsp_valid, cpu_rsp_err;
  logic [DW-1:0] cpu_rdata;
  logic          mem_req_valid, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_data_valid;
  logic [DW-1:0] mem_rdata;
  logic          busy;

  int checks = 0;
  int errors = 0;

  mem_req_bridge #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .DEPTH      (4),
    .TIMEOUT    (16)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .cpu_req_valid  (cpu_req_valid),
    .cpu_req_ready  (cpu_req_ready),
    .cpu_we         (cpu_we),
    .cpu_addr       (cpu_addr),
    .cpu_wdata      (cpu_wdata),
    .cpu_rsp_valid  (cpu_rsp_valid),
    .cpu_rdata      (cpu_rdata),
    .cpu_rsp_err    (cpu_rsp_err),
    .mem_req_valid  (mem_req_valid),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_data_valid (mem_data_valid),
    .mem_rdata      (mem_rdata),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached (got hang, want completion)");
    $fatal(1, "watchdog");
  end

  // Advance one cycle; a request accepted at this edge is withdrawn afterwards.
  task automatic step();
    logic acc;
    acc = cpu_req_valid && cpu_req_ready;
    @(posedge clk);
    #1;
    if (acc) cpu_req_valid = 1'b0;
  endtask

  task automatic drive_req(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    cpu_req_valid = 1'b1;
    cpu_we        = we;
    cpu_addr      = a;
    cpu_wdata     = d;
  endtask

  task automatic wait_mem_req(input string name);
    int n;
    n = 0;
    while (mem_req_valid !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    checks++;
    if (mem_req_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s_wait: mem_req_valid=%b, want 1 within 50 cycles", name, mem_req_valid);
    end
  endtask

  // Ack the outstanding read with data and expect a clean response next cycle.
  task automatic serve(input logic [AW-1:0] exp_addr, input logic [DW-1:0] data,
                       input string name);
    wait_mem_req(name);
    checks++;
    if (mem_addr !== exp_addr) begin
      errors++;
      $display("FAIL %s_addr: mem_addr=%0d, want %0d", name, mem_addr, exp_addr);
    end
    mem_data_valid = 1'b1;
    mem_rdata      = data;
    step();
    mem_data_valid = 1'b0;
    mem_rdata      = '0;
    checks++;
    if (cpu_rsp_valid !== 1'b1 || cpu_rdata !== data || cpu_rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL %s_rsp: valid=%b rdata=%h err=%b, want 1 %h 0", name, cpu_rsp_valid,
               cpu_rdata, cpu_rsp_err, data);
    end
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    checks++;
    if ({cpu_req_ready, cpu_rsp_valid, cpu_rsp_err, mem_req_valid, mem_we, busy} !== 6'b100000 ||
        cpu_rdata !== '0 || mem_addr !== '0 || mem_wdata !== '0) begin
      errors++;
      $display("FAIL reset_values: rdy=%b rv=%b err=%b mrv=%b we=%b busy=%b rdata=%h addr=%h wd=%h, want 1 0 0 0 0 0 0 0 0",
               cpu_req_ready, cpu_rsp_valid, cpu_rsp_err, mem_req_valid, mem_we, busy,
               cpu_rdata, mem_addr, mem_wdata);
    end
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_single_read();
    drive_req(1'b0, 6'd5, '0);               // cycle 0
    step();                                  // cycle 1
    checks++;
    if (mem_req_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL read_c1: mem_req_valid=%b busy=%b, want 0 1", mem_req_valid, busy);
    end
    step();                                  // cycle 2
    checks++;
    if (mem_req_valid !== 1'b1 || mem_addr !== 6'd5 || mem_we !== 1'b0) begin
      errors++;
      $display("FAIL read_c2: mrv=%b addr=%0d we=%b, want 1 5 0", mem_req_valid, mem_addr, mem_we);
    end
    step();                                  // cycle 3
    step();                                  // cycle 4
    mem_data_valid = 1'b1;
    mem_rdata      = 32'hDEADBEEF;
    checks++;
    if (cpu_rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL read_early_rsp: cpu_rsp_valid=%b at cycle 4, want 0", cpu_rsp_valid);
    end
    step();                                  // cycle 5
    mem_data_valid = 1'b0;
    mem_rdata      = '0;
    checks++;
    if (cpu_rsp_valid !== 1'b1 || cpu_rdata !== 32'hDEADBEEF || cpu_rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL read_rsp: valid=%b rdata=%h err=%b, want 1 deadbeef 0", cpu_rsp_valid,
               cpu_rdata, cpu_rsp_err);
    end
    step();                                  // cycle 6
    checks++;
    if (cpu_rsp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL read_done: valid=%b busy=%b, want 0 0", cpu_rsp_valid, busy);
    end
  endtask

  task automatic test_single_write();
    int bad;
    bad = 0;
    drive_req(1'b1, 6'd3, 32'h12345678);
    step();
    step();
    for (int c = 0; c < 4; c++) begin
      if (mem_req_valid !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 6'd3 ||
          mem_wdata !== 32'h12345678) bad++;
      if (c < 3) step();
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL write_hold: %0d unstable cycles, want 0 (last mrv=%b we=%b addr=%0d wd=%h)",
               bad, mem_req_valid, mem_we, mem_addr, mem_wdata);
    end
    mem_data_valid = 1'b1;
    mem_rdata      = 32'hFFFFFFFF;           // must not leak into a write response
    step();
    mem_data_valid = 1'b0;
    mem_rdata      = '0;
    checks++;
    if (cpu_rsp_valid !== 1'b1 || cpu_rdata !== '0 || cpu_rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL write_rsp: valid=%b rdata=%h err=%b, want 1 0 0", cpu_rsp_valid, cpu_rdata,
               cpu_rsp_err);
    end
    step();
  endtask

  task automatic test_back_to_back();
    drive_req(1'b0, 6'd20, '0);
    step();
    wait_mem_req("fill_p0");
    for (int i = 0; i < 4; i++) begin
      drive_req(1'b0, AW'(10 + i), '0);
      checks++;
      if (cpu_req_ready !== 1'b1) begin
        errors++;
        $display("FAIL fill_ready_%0d: cpu_req_ready=%b, want 1", i, cpu_req_ready);
      end
      step();
    end
    drive_req(1'b0, 6'd14, '0);              // fifth request, must wait for a slot
    checks++;
    if (cpu_req_ready !== 1'b0) begin
      errors++;
      $display("FAIL fill_full: cpu_req_ready=%b, want 0", cpu_req_ready);
    end
    step();
    checks++;
    if (cpu_req_ready !== 1'b0 || mem_addr !== 6'd20) begin
      errors++;
      $display("FAIL fill_held: ready=%b mem_addr=%0d, want 0 20", cpu_req_ready, mem_addr);
    end
    serve(6'd20, 32'hA000_0014, "fill_p0");
    for (int i = 0; i < 5; i++) begin
      serve(AW'(10 + i), 32'hA000_0000 + DW'(10 + i), $sformatf("fill_%0d", i));
    end
    checks++;
    if (busy !== 1'b0 || cpu_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL fill_drain: busy=%b pending_valid=%b, want 0 0", busy, cpu_req_valid);
    end
  endtask

  task automatic test_timeout();
    int n;
    drive_req(1'b0, 6'd7, '0);
    step();
    drive_req(1'b0, 6'd8, '0);
    step();
    n = 0;
    while (mem_req_valid === 1'b1 && n < 40) begin
      step();
      n++;
    end
    checks++;
    if (n != 16) begin
      errors++;
      $display("FAIL timeout_len: mem_req_valid high %0d cycles, want 16", n);
    end
    checks++;
    if (cpu_rsp_valid !== 1'b1 || cpu_rsp_err !== 1'b1 || cpu_rdata !== '0) begin
      errors++;
      $display("FAIL timeout_rsp: valid=%b err=%b rdata=%h, want 1 1 0", cpu_rsp_valid,
               cpu_rsp_err, cpu_rdata);
    end
    step();
    serve(6'd8, 32'h0BAD_F00D, "timeout_next");
  endtask

  task automatic test_race();
    int bad;
    drive_req(1'b0, 6'd9, '0);
    step();
    wait_mem_req("race");
    for (int i = 0; i < 15; i++) step();
    checks++;
    if (mem_req_valid !== 1'b1) begin
      errors++;
      $display("FAIL race_c16: mem_req_valid=%b in 16th busy cycle, want 1", mem_req_valid);
    end
    mem_data_valid = 1'b1;
    mem_rdata      = 32'h55AA55AA;
    step();
    mem_data_valid = 1'b0;
    mem_rdata      = '0;
    checks++;
    if (cpu_rsp_valid !== 1'b1 || cpu_rsp_err !== 1'b0 || cpu_rdata !== 32'h55AA55AA) begin
      errors++;
      $display("FAIL race_rsp: valid=%b err=%b rdata=%h, want 1 0 55aa55aa", cpu_rsp_valid,
               cpu_rsp_err, cpu_rdata);
    end
    step();
    mem_data_valid = 1'b1;                   // spurious ack while idle
    mem_rdata      = 32'h11111111;
    step();
    mem_data_valid = 1'b0;
    mem_rdata      = '0;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      if (cpu_rsp_valid !== 1'b0 || mem_req_valid !== 1'b0 || busy !== 1'b0) bad++;
      step();
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL spurious_ack: %0d cycles with activity, want 0", bad);
    end
  endtask

  task automatic test_reset_mid_busy();
    int bad;
    drive_req(1'b0, 6'd1, '0);
    step();
    wait_mem_req("rst_mid");
    drive_req(1'b1, 6'd2, 32'hCAFE0002);
    step();
    drive_req(1'b0, 6'd3, '0);
    step();
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({cpu_req_ready, cpu_rsp_valid, cpu_rsp_err, mem_req_valid, mem_we, busy} !== 6'b100000 ||
        cpu_rdata !== '0 || mem_addr !== '0 || mem_wdata !== '0) begin
      errors++;
      $display("FAIL rst_mid_async: rdy=%b rv=%b err=%b mrv=%b we=%b busy=%b rdata=%h addr=%h wd=%h, want 1 0 0 0 0 0 0 0 0",
               cpu_req_ready, cpu_rsp_valid, cpu_rsp_err, mem_req_valid, mem_we, busy,
               cpu_rdata, mem_addr, mem_wdata);
    end
    step();
    step();
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      if (cpu_rsp_valid !== 1'b0 || mem_req_valid !== 1'b0 || cpu_req_ready !== 1'b1) bad++;
      step();
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL rst_mid_quiet: %0d cycles with activity after reset, want 0", bad);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_busy: busy=%b, want 0", busy);
    end
  endtask

  initial begin
    reset          = 1'b1;
    cpu_req_valid  = 1'b0;
    cpu_we         = 1'b0;
    cpu_addr       = '0;
    cpu_wdata      = '0;
    mem_data_valid = 1'b0;
    mem_rdata      = '0;
    test_reset();
    test_single_read();
    test_single_write();
    test_back_to_back();
    test_timeout();
    test_race();
    test_reset_mid_busy();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
